gemv_mul_rr_arbiter: RTL

Shares one signed DW x DW multiplier among NUM_REQ requesters in the gemv accelerator, replacing per-loop multiplier instances. The block uses round-robin arbitration with valid/ready handshakes on each request port. It has a single registered result channel that carries the winning requester's ID and supports backpressure. It sits between the gemv row/column loop engines and the shared multiplier resource.

---
 rtl/gemv_mul_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gemv_mul_rr_arbiter.sv
// gemv_mul_rr_arbiter
// Shares one signed DW x DW multiplier among NUM_REQ requesters using
// round-robin arbitration. The result register carries the product (the low
// DW bits of the signed full product) and the ID of the requester that
// issued it. The result channel supports backpressure.
//
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   req_valid / req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_din0 / req_din1     packed operands, requester i at [i*DW +: DW]
//   resp_valid / resp_ready result handshake
//   resp_id / resp_dout     issuing requester index / product
//   ops_done                count of consumed results, wraps at 2**32
//
// Build option:
//   GEMV_MUL_ARB_PIPE_EN  adds an operand stage in front of the multiplier.
//                         Latency becomes 2 cycles and full throughput is kept.
module gemv_mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int ID_W    = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_din0,
    input  logic [NUM_REQ*DW-1:0] req_din1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [DW-1:0]         resp_dout,
    output logic [31:0]           ops_done
);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 resp_valid_q;
    logic [ID_W-1:0]      resp_id_q;
    logic [DW-1:0]        resp_dout_q;
    logic [31:0]          ops_done_q;

    logic                 slot_free;
    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_id;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [DW-1:0]        op_a, op_b;
    logic [DW-1:0]        mul_a, mul_b;
    logic [DW-1:0]        prod;
    logic                 consume;

    assign consume = resp_valid_q && resp_ready;

`ifdef GEMV_MUL_ARB_PIPE_EN
    logic            s0_valid_q;
    logic [DW-1:0]   s0_a_q, s0_b_q;
    logic [ID_W-1:0] s0_id_q;
    logic            advance;

    // s0 can move on whenever the result register is empty or being drained.
    assign advance   = !resp_valid_q || resp_ready;
    assign slot_free = !s0_valid_q || advance;
    assign mul_a     = s0_a_q;
    assign mul_b     = s0_b_q;
`else
    assign slot_free = !resp_valid_q || resp_ready;
    assign mul_a     = op_a;
    assign mul_b     = op_b;
`endif

    // Rotate the request vector so that bit k corresponds to requester ptr+k.
    // Scanning k from high to low leaves the lowest set k as the winner.
    always_comb begin
        req_dbl   = {req_valid, req_valid} >> ptr_q;
        req_rot   = req_dbl[NUM_REQ-1:0];
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        if (!slot_free || ap_rst) begin
            gnt_found = 1'b0;
        end
        ptr_d = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
    end

    assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_id) : '0;
    assign op_a      = req_din0[int'(gnt_id)*DW +: DW];
    assign op_b      = req_din1[int'(gnt_id)*DW +: DW];

    // Low DW bits of the signed product; truncation wraps silently.
    assign prod = $signed(mul_a) * $signed(mul_b);

`ifdef GEMV_MUL_ARB_PIPE_EN
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q        <= '0;
            s0_valid_q   <= 1'b0;
            s0_a_q       <= '0;
            s0_b_q       <= '0;
            s0_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_dout_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            if (consume) begin
                ops_done_q <= ops_done_q + 32'd1;
            end
            if (advance) begin
                resp_valid_q <= s0_valid_q;
                if (s0_valid_q) begin
                    resp_id_q   <= s0_id_q;
                    resp_dout_q <= prod;
                end
            end
            if (gnt_found) begin
                s0_valid_q <= 1'b1;
                s0_a_q     <= op_a;
                s0_b_q     <= op_b;
                s0_id_q    <= gnt_id;
                ptr_q      <= ptr_d;
            end else if (advance) begin
                s0_valid_q <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_dout_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            if (consume) begin
                ops_done_q <= ops_done_q + 32'd1;
            end
            if (gnt_found) begin
                resp_valid_q <= 1'b1;
                resp_id_q    <= gnt_id;
                resp_dout_q  <= prod;
                ptr_q        <= ptr_d;
            end else if (consume) begin
                resp_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_dout  = resp_dout_q;
    assign ops_done   = ops_done_q;

endmodule
